line_window_5: RTL and testbench

LINE_WINDOW_5 -- requirements
Module: line_window_5

---
 rtl/cnn_pkg.sv | 18 +
 rtl/line_fifo.sv | 27 ++
 rtl/line_window_5.sv | 185 ++++++++++++++++++
 tb/tb_line_window_5.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN types: FP16 word, default kernel geometry and the line-window FSM states.
package cnn_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int KERNEL_SIZE = 5;

   typedef logic [DATA_WIDTH-1:0] fp16_t;

   typedef enum logic [2:0] {
      IDLE,
      KLOAD,
      KEMIT,
      FILL,
      STREAM,
      DONE
   } state_t;

endpackage

// File: rtl/line_fifo.sv
// One image row of delay: a DEPTH-deep shift register that advances only when en_i is high.
// dout_o is the word shifted in DEPTH enabled cycles earlier; there is no backpressure.
module line_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 28
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   logic [DATA_WIDTH-1:0] sr_q [DEPTH];

   // Contents are never cleared; downstream valid gating hides stale words.
   always_ff @(posedge clk) begin
      if (en_i) begin
         sr_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/line_window_5.sv
// Loads a 5x5 kernel, replays it as 5 column vectors, then streams 5-row image columns.
// Vectors appear one cycle after each accepted word, valid_out one cycle later; no backpressure.
module line_window_5 #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 5,
   parameter int IMG_W       = 28,
   parameter int IMG_H       = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic [DATA_WIDTH-1:0] data_out0,
   output logic [DATA_WIDTH-1:0] data_out1,
   output logic [DATA_WIDTH-1:0] data_out2,
   output logic [DATA_WIDTH-1:0] data_out3,
   output logic [DATA_WIDTH-1:0] data_out4,
   output logic                  kernel_load,
   output logic                  valid_in,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  frame_done
);

   import cnn_pkg::*;

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int KW = $clog2(KERNEL_SIZE);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_SIZE - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_PRE  = RW'(KERNEL_SIZE - 2);
   localparam logic [KW-1:0] K_LAST   = KW'(KERNEL_SIZE - 1);

   state_t                state_q;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [KW-1:0]         kr_q, kc_q;
   logic [DATA_WIDTH-1:0] dout_q [KERNEL_SIZE];
   logic [DATA_WIDTH-1:0] w_q    [KERNEL_SIZE][KERNEL_SIZE];
   logic                  kl_q, vin_q, win_q, vout_q, fd_q;
   logic                  pix_en;

   // chain[0] is the live row; chain[k] is the same column k rows earlier.
   logic [DATA_WIDTH-1:0] chain [KERNEL_SIZE];

   // Pixels are also accepted during KEMIT so a source that streams straight on loses nothing.
   assign pix_en = word_valid && (state_q == KEMIT || state_q == FILL || state_q == STREAM);

   assign chain[0] = word_in;

   for (genvar g = 0; g < KERNEL_SIZE - 1; g++) begin : g_line
      line_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (IMG_W)
      ) u_line (
         .clk    (clk),
         .en_i   (pix_en),
         .din_i  (chain[g]),
         .dout_o (chain[g+1])
      );
   end

   always_comb begin
      col_d = col_q + 1'b1;
      row_d = row_q;
      if (col_q == COL_LAST) begin
         col_d = '0;
         row_d = row_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state_q == KLOAD && word_valid) begin
         w_q[kr_q][kc_q] <= word_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         kr_q    <= '0;
         kc_q    <= '0;
         for (int n = 0; n < KERNEL_SIZE; n++) begin
            dout_q[n] <= '0;
         end
         kl_q    <= 1'b0;
         vin_q   <= 1'b0;
         win_q   <= 1'b0;
         vout_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         kl_q   <= 1'b0;
         vin_q  <= 1'b0;
         win_q  <= 1'b0;
         fd_q   <= 1'b0;
         vout_q <= win_q;
         if (pix_en) begin
            col_q <= col_d;
            row_q <= row_d;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= KLOAD;
                  kr_q    <= '0;
                  kc_q    <= '0;
                  col_q   <= '0;
                  row_q   <= '0;
               end
            end
            KLOAD: begin
               if (word_valid) begin
                  if (kc_q == K_LAST) begin
                     kc_q <= '0;
                     if (kr_q == K_LAST) begin
                        kr_q    <= '0;
                        state_q <= KEMIT;
                     end else begin
                        kr_q <= kr_q + 1'b1;
                     end
                  end else begin
                     kc_q <= kc_q + 1'b1;
                  end
               end
            end
            KEMIT: begin
               // kc_q doubles as the kernel column index j here.
               for (int n = 0; n < KERNEL_SIZE; n++) begin
                  dout_q[n] <= w_q[n][kc_q];
               end
               kl_q  <= 1'b1;
               vin_q <= 1'b1;
               if (kc_q == K_LAST) begin
                  kc_q    <= '0;
                  state_q <= FILL;
               end else begin
                  kc_q <= kc_q + 1'b1;
               end
            end
            FILL: begin
               if (pix_en && col_q == COL_LAST && row_q == ROW_PRE) begin
                  state_q <= STREAM;
               end
            end
            STREAM: begin
               if (pix_en) begin
                  for (int n = 0; n < KERNEL_SIZE; n++) begin
                     dout_q[n] <= chain[KERNEL_SIZE-1-n];
                  end
                  vin_q <= 1'b1;
                  win_q <= (col_q >= COL_MIN);
                  if (col_q == COL_LAST && row_q == ROW_LAST) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               fd_q    <= 1'b1;
               col_q   <= '0;
               row_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out0   = dout_q[0];
   assign data_out1   = dout_q[1];
   assign data_out2   = dout_q[2];
   assign data_out3   = dout_q[3];
   assign data_out4   = dout_q[4];
   assign kernel_load = kl_q;
   assign valid_in    = vin_q;
   assign valid_out   = vout_q;
   assign frame_done  = fd_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_line_window_5.sv
// Bench for line_window_5: an 8x8 instance and a default 28x28 instance, selected by sel.
module tb_line_window_5;
   import cnn_pkg::*;

   logic  clk = 1'b0;
   always #5 clk = ~clk;

   logic  rst, start, wv, sel;
   fp16_t word;

   fp16_t d_a [5];
   fp16_t d_b [5];
   fp16_t md  [5];
   logic  kl_a, vin_a, vo_a, busy_a, fd_a;
   logic  kl_b, vin_b, vo_b, busy_b, fd_b;
   logic  m_kl, m_vin, m_vo, m_busy, m_fd;

   line_window_5 #(.IMG_W(8), .IMG_H(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start & ~sel), .word_in(word), .word_valid(wv & ~sel),
      .data_out0(d_a[0]), .data_out1(d_a[1]), .data_out2(d_a[2]), .data_out3(d_a[3]),
      .data_out4(d_a[4]), .kernel_load(kl_a), .valid_in(vin_a), .valid_out(vo_a),
      .busy(busy_a), .frame_done(fd_a)
   );

   line_window_5 u_dut (
      .clk(clk), .rst(rst), .start(start & sel), .word_in(word), .word_valid(wv & sel),
      .data_out0(d_b[0]), .data_out1(d_b[1]), .data_out2(d_b[2]), .data_out3(d_b[3]),
      .data_out4(d_b[4]), .kernel_load(kl_b), .valid_in(vin_b), .valid_out(vo_b),
      .busy(busy_b), .frame_done(fd_b)
   );

   always_comb begin
      for (int n = 0; n < 5; n++) md[n] = sel ? d_b[n] : d_a[n];
      m_kl   = sel ? kl_b   : kl_a;
      m_vin  = sel ? vin_b  : vin_a;
      m_vo   = sel ? vo_b   : vo_a;
      m_busy = sel ? busy_b : busy_a;
      m_fd   = sel ? fd_b   : fd_a;
   end

   typedef struct {
      logic [79:0] dat;
      logic        kl;
      logic        vo;
   } exp_t;

   typedef struct {
      logic  r;
      logic  s;
      logic  v;
      fp16_t w;
      logic  e_busy;
   } step_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_err = 0;
   int   vo_cnt, fd_cnt, kv_cnt, iv_cnt;
   bit   vo_pend = 1'b0;
   logic rst_seen = 1'b1;

   task automatic chk(input bit ok, input string nm, input logic [95:0] act, input logic [95:0] req);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic fp16_t pix(input int r, input int c, input int w, input int seed);
      return fp16_t'(r * w + c + seed * 997);
   endfunction

   always @(posedge clk) rst_seen <= rst;

   // Scoreboard: every vector on valid_in pops one expected record.
   always @(negedge clk) begin
      exp_t e;
      if (rst_seen) begin
         vo_pend = 1'b0;
      end else begin
         if (vo_pend || m_vo) chk(m_vo == vo_pend, "valid_out", 96'(m_vo), 96'(vo_pend));
         vo_pend = 1'b0;
         if (m_vo) vo_cnt++;
         if (m_fd) fd_cnt++;
         if (m_vin) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_vector", {15'b0, m_kl, md[0], md[1], md[2], md[3], md[4]}, 96'b0);
            end else begin
               e = exp_q.pop_front();
               chk({m_kl, md[0], md[1], md[2], md[3], md[4]} == {e.kl, e.dat}, "vector",
                   {15'b0, m_kl, md[0], md[1], md[2], md[3], md[4]}, {15'b0, e.kl, e.dat});
               if (m_kl) kv_cnt++; else iv_cnt++;
               vo_pend = e.vo && !e.kl;
            end
         end
      end
   end

   task automatic gap_wait(input int gap);
      while ($urandom_range(0, 99) < gap) begin
         wv = 1'b0;
         tick();
      end
   endtask

   task automatic run_frame(input int w, input int h, input int seed, input int gap,
                            input bit mid, input int abort_r);
      exp_t e;
      int   n;
      vo_cnt = 0; fd_cnt = 0; kv_cnt = 0; iv_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 25; i++) begin
         gap_wait(gap);
         word = 16'h3C00 + 16'(i);
         wv   = 1'b1;
         if (i == 24) begin
            for (int j = 0; j < 5; j++) begin
               e.kl = 1'b1;
               e.vo = 1'b0;
               for (int k = 0; k < 5; k++) e.dat[(4-k)*16 +: 16] = 16'h3C00 + 16'(5*k + j);
               exp_q.push_back(e);
            end
         end
         tick();
      end
      wv = 1'b0;
      repeat (8) tick();
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (r == abort_r && c == 3) begin
               wv  = 1'b0;
               rst = 1'b1;
               tick();
               rst = 1'b0;
               chk({m_busy, m_vin, m_kl, m_vo, m_fd} == 5'b0, "abort_reset",
                   96'({m_busy, m_vin, m_kl, m_vo, m_fd}), 96'b0);
               exp_q.delete();
               tick();
               return;
            end
            gap_wait(gap);
            word  = pix(r, c, w, seed);
            wv    = 1'b1;
            start = mid && r == 6 && c == 5;
            if (r >= 4) begin
               e.kl = 1'b0;
               e.vo = (c >= 4);
               for (int k = 0; k < 5; k++) e.dat[(4-k)*16 +: 16] = pix(r - 4 + k, c, w, seed);
               exp_q.push_back(e);
            end
            tick();
            start = 1'b0;
         end
      end
      wv = 1'b0;
      n  = 0;
      do begin
         tick();
         #5;
         n++;
      end while (fd_cnt == 0 && n < 60);
      chk(fd_cnt == 1, "frame_done_count", 96'(fd_cnt), 96'd1);
      chk(vo_cnt == (h-4)*(w-4), "valid_out_count", 96'(vo_cnt), 96'((h-4)*(w-4)));
      chk(iv_cnt == (h-4)*w, "image_vector_count", 96'(iv_cnt), 96'((h-4)*w));
      chk(kv_cnt == 5, "kernel_vector_count", 96'(kv_cnt), 96'd5);
      chk(exp_q.size() == 0, "pending_vectors", 96'(exp_q.size()), 96'd0);
      chk(m_busy == 1'b0, "busy_after_frame", 96'(m_busy), 96'd0);
   endtask

   initial begin
      step_t steps [7];
      steps[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
      steps[1] = '{1'b0, 1'b0, 1'b1, 16'h1234, 1'b0};
      steps[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
      steps[3] = '{1'b1, 1'b1, 1'b1, 16'h5555, 1'b0};
      steps[4] = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b0};
      steps[5] = '{1'b0, 1'b1, 1'b1, 16'h3C00, 1'b1};
      steps[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

      rst = 1'b1; start = 1'b0; wv = 1'b0; word = '0; sel = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state, idle-word rejection, start, and reset dominance on the 8x8 instance.
      for (int i = 0; i < 7; i++) begin
         rst = steps[i].r; start = steps[i].s; wv = steps[i].v; word = steps[i].w;
         tick();
         rst = 1'b0; start = 1'b0; wv = 1'b0;
         chk({m_busy, m_vin, m_kl, m_vo, m_fd, md[0], md[1], md[2], md[3], md[4]}
             == {steps[i].e_busy, 84'b0}, $sformatf("step%0d", i),
             {11'b0, m_busy, m_vin, m_kl, m_vo, m_fd, md[0], md[1], md[2], md[3], md[4]},
             {11'b0, steps[i].e_busy, 84'b0});
      end
      tick();

      run_frame(8, 8, 0, 0, 1'b0, -1);

      sel = 1'b1;
      repeat (2) tick();
      run_frame(28, 28, 1, 0, 1'b0, -1);
      run_frame(28, 28, 1, 50, 1'b0, -1);
      run_frame(28, 28, 2, 0, 1'b0, 10);
      run_frame(28, 28, 2, 0, 1'b0, -1);
      run_frame(28, 28, 3, 0, 1'b1, -1);
      run_frame(28, 28, 4, 0, 1'b0, -1);
      run_frame(28, 28, 4, 0, 1'b0, -1);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
